instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit: the initiator side of the instruction-memory read interface. It drives a 22-bit word address into `instrMem`, captures the 32-bit combinational read data each cycle, and buffers fetched words with their PCs in a small FIFO. It hands the words to decode over a valid/ready handshake, and accepts branch redirects from execute.

## Interface
Parameters:
- `RESET_PC`, 22'd0: word address fetched first after reset.
- `DEPTH`, 2: prefetch FIFO entries; power of two, ≥2.
- `HALT_OPCODE`, 32'hFFFF_FFFF: fetched word that stops fetching.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `imem_addr` output 22: word address to `instrMem`. Always equals the internal PC.
- `imem_data` input 32: combinational read data for `imem_addr`, valid in the same cycle.
- `redirect_valid` input 1: branch/jump taken this cycle.
- `redirect_pc` input 22: new fetch address.
- `instr_valid` output 1: FIFO head is valid.
- `instr` output 32: FIFO head instruction word.
- `instr_pc` output 22: address the head word was fetched from.
- `decode_ready` input 1: decode consumes the head when `instr_valid` and `decode_ready` are both high.
- `halted` output 1: fetch is stopped on `HALT_OPCODE`.

## Operation
- State machine:
  - RUN: fetching.
  - HALT: not fetching; FIFO still drains.
- Reset (`reset`=1 at an edge) sets:
  - PC=`RESET_PC`, state=RUN.
  - FIFO emptied (count=0, read/write pointers 0).
  - `halted`=0, and `instr`/`instr_pc` read 0.
- Reset mid-operation discards all buffered words.
- pop = `instr_valid` & `decode_ready`.
- push (RUN only) = !`redirect_valid` & (count<DEPTH | pop). The pushed entry is {`imem_data`, PC}. PC then increments by 1, wrapping 22'h3FFFFF→0.
- A push with `imem_data`==`HALT_OPCODE` still stores the word. The state goes to HALT, PC advances, and `halted`=1 from the next cycle.
- Redirect (priority over push and pop in every state):
  - FIFO is flushed (count=0), PC=`redirect_pc`, state=RUN, `halted`=0.
  - The word on `imem_data` that cycle is discarded.
  - A pop requested in the same cycle is not counted as consumed; decode must ignore it.
- FIFO full and no pop: no push, PC holds, `imem_addr` stable.
- Full with simultaneous pop and push: count unchanged, both pointers advance modulo DEPTH.
- Empty: `instr_valid`=0, and `instr`/`instr_pc` show the stale entry at the read pointer.
- Count width is clog2(DEPTH)+1. Pointers are clog2(DEPTH) bits, wrapping naturally.

## Timing
- Fetch-to-valid latency 1 cycle: a word pushed at edge N is visible on `instr` with `instr_valid`=1 after edge N.
- First valid instruction appears 1 cycle after `reset` deasserts.
- Steady state with `decode_ready`=1: one instruction per cycle, PCs consecutive.
- Redirect:
  - Asserted in cycle N: `imem_addr`=`redirect_pc` after edge N, and `instr_valid`=0 during cycle N+1.
  - The first redirected word is valid in cycle N+2, so the taken-branch bubble is 1 cycle.
- Backpressure: with `decode_ready`=0 the FIFO fills in DEPTH cycles from empty. After that, PC and outputs hold.
- HALT: `halted` rises the cycle after the halt word is pushed. Nothing is pushed while in HALT.
- All outputs are registered or derived from registered state only. There are no combinational paths from inputs to outputs, so `imem_addr` does not depend on `redirect_valid` within a cycle.

## Test plan
- Reset, then `decode_ready`=1, memory word[i]=i+32'h100:
  - `imem_addr` steps 0,1,2,…
  - `instr_valid`=1 from cycle 1, with `instr`=0x100,0x101,… and `instr_pc`=0,1,….
- Backpressure: `decode_ready`=0 for 5 cycles after reset.
  - FIFO holds words 0,1; `imem_addr` stays at 2.
  - Then `decode_ready`=1: the stream resumes 0,1,2,3 with no loss or duplication.
- Redirect in cycle 4 to 22'h0000FF while the FIFO is non-empty:
  - Cycle 5: `instr_valid`=0.
  - Cycle 6: `instr_pc`=0xFF, `instr`=word[0xFF].
  - No pre-redirect word appears after cycle 4.
- Halt: word[3]=32'hFFFFFFFF.
  - Words 0–3 are delivered, then `halted`=1 and `imem_addr` holds at 4.
  - A redirect to 10 clears `halted` and word 10 is delivered.
- Wrap: redirect to 22'h3FFFFE, then `instr_pc` reads 3FFFFE, 3FFFFF, 000000.
- Reset mid-stream with the FIFO full:
  - The next cycle has `instr_valid`=0 and `imem_addr`=`RESET_PC`.
  - A redirect asserted in the same cycle as reset is ignored.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch: drives imem_addr, buffers {word, pc} in a prefetch FIFO,
// hands words to decode via valid/ready, takes redirects, stops on HALT_OPCODE.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   imem_addr / imem_data       instruction memory read (combinational data)
//   redirect_valid/redirect_pc  branch redirect from execute
//   instr_valid/instr/instr_pc  FIFO head towards decode
//   decode_ready                decode consumes head when valid & ready
//   halted                      fetch stopped after a halt word
module instr_fetch #(
  parameter logic [21:0] RESET_PC    = 22'd0,
  parameter int          DEPTH       = 2,
  parameter logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [21:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [21:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [21:0] instr_pc,
  input  logic        decode_ready,
  output logic        halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, HALT} state_t;

  state_t          state;
  state_t          state_next;
  logic [21:0]     pc;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [31:0]     fifo_instr [DEPTH];
  logic [21:0]     fifo_pc    [DEPTH];
  logic            pop;
  logic            push;

  assign imem_addr   = pc;
  assign instr_valid = (count != '0);
  assign instr       = fifo_instr[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];
  assign halted      = (state == HALT);

  always_comb begin
    state_next = state;
    push       = 1'b0;
    pop        = instr_valid & decode_ready;
    if (redirect_valid) begin
      state_next = RUN;
    end else if (state == RUN) begin
      push = (count < CW'(DEPTH)) | pop;
      if (push && imem_data == HALT_OPCODE)
        state_next = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        // Flush: a same-cycle pop is dropped, decode must ignore it.
        count  <= '0;
        rd_ptr <= wr_ptr;
        pc     <= redirect_pc;
      end else begin
        if (push) begin
          fifo_instr[wr_ptr] <= imem_data;
          fifo_pc[wr_ptr]    <= pc;
          wr_ptr             <= wr_ptr + PW'(1);
          pc                 <= pc + 22'd1;
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed phases push expected
// {instr, pc} into a queue; a negedge monitor checks every consumed word.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [21:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [21:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [21:0] instr_pc;
  logic        decode_ready = 1'b0;
  logic        halted;

  logic        halt_en = 1'b0;
  logic [21:0] halt_addr = '0;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] w;
    logic [21:0] a;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  assign imem_data = (halt_en && imem_addr == halt_addr) ?
                     32'hFFFF_FFFF : {10'd0, imem_addr} + 32'h100;

  instr_fetch #(
    .RESET_PC(22'd0),
    .DEPTH(2),
    .HALT_OPCODE(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .decode_ready(decode_ready),
    .halted(halted)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] w, input logic [21:0] a);
    exp_t e;
    e.w = w;
    e.a = a;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && !redirect_valid && instr_valid && decode_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected: pc %h instr %h", instr_pc, instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_instr", instr, e.w);
        chk("sb_pc", {10'd0, instr_pc}, {10'd0, e.a});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    decode_ready = 1'b0;
    step();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", {10'd0, instr_pc}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_addr", {10'd0, imem_addr}, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    step();

    // Streaming
    do_reset();
    decode_ready = 1'b1;
    for (int i = 0; i < 6; i++)
      exp_push(32'h100 + i, 22'(i));
    for (int c = 0; c <= 6; c++) begin
      chk("stream_addr", {10'd0, imem_addr}, c);
      if (c == 0)
        chk("stream_v0", {31'd0, instr_valid}, 32'd0);
      step();
    end

    // Backpressure
    do_reset();
    repeat (5) step();
    chk("bp_addr", {10'd0, imem_addr}, 32'd2);
    chk("bp_valid", {31'd0, instr_valid}, 32'd1);
    chk("bp_pc", {10'd0, instr_pc}, 32'd0);
    exp_push(32'h100, 22'd0);
    exp_push(32'h101, 22'd1);
    exp_push(32'h102, 22'd2);
    exp_push(32'h103, 22'd3);
    decode_ready = 1'b1;
    step();
    chk("bp_addr2", {10'd0, imem_addr}, 32'd3);
    repeat (3) step();

    // Redirect
    do_reset();
    decode_ready = 1'b1;
    exp_push(32'h100, 22'd0);
    exp_push(32'h101, 22'd1);
    exp_push(32'h102, 22'd2);
    exp_push(32'h1FF, 22'h0000FF);
    exp_push(32'h200, 22'h000100);
    exp_push(32'h201, 22'h000101);
    repeat (4) step();
    chk("rd_v4", {31'd0, instr_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 22'h0000FF;
    step();
    redirect_valid = 1'b0;
    chk("rd_v5", {31'd0, instr_valid}, 32'd0);
    chk("rd_addr5", {10'd0, imem_addr}, 32'h0FF);
    step();
    chk("rd_pc6", {10'd0, instr_pc}, 32'h0FF);
    repeat (3) step();

    // Halt
    halt_en = 1'b1;
    halt_addr = 22'd3;
    do_reset();
    decode_ready = 1'b1;
    exp_push(32'h100, 22'd0);
    exp_push(32'h101, 22'd1);
    exp_push(32'h102, 22'd2);
    exp_push(32'hFFFF_FFFF, 22'd3);
    exp_push(32'h10A, 22'd10);
    exp_push(32'h10B, 22'd11);
    repeat (3) step();
    chk("h_halted3", {31'd0, halted}, 32'd0);
    step();
    chk("h_halted4", {31'd0, halted}, 32'd1);
    chk("h_addr4", {10'd0, imem_addr}, 32'd4);
    step();
    step();
    chk("h_v6", {31'd0, instr_valid}, 32'd0);
    chk("h_addr6", {10'd0, imem_addr}, 32'd4);
    redirect_valid = 1'b1;
    redirect_pc = 22'd10;
    step();
    redirect_valid = 1'b0;
    chk("h_halted7", {31'd0, halted}, 32'd0);
    chk("h_addr7", {10'd0, imem_addr}, 32'd10);
    repeat (3) step();
    halt_en = 1'b0;

    // Wrap
    do_reset();
    decode_ready = 1'b1;
    exp_push(32'h004000FE, 22'h3FFFFE);
    exp_push(32'h004000FF, 22'h3FFFFF);
    exp_push(32'h00000100, 22'h000000);
    redirect_valid = 1'b1;
    redirect_pc = 22'h3FFFFE;
    step();
    redirect_valid = 1'b0;
    chk("w_addr", {10'd0, imem_addr}, 32'h3FFFFE);
    repeat (4) step();

    // Reset mid-stream, full FIFO, redirect alongside reset
    do_reset();
    repeat (3) step();
    chk("mr_valid", {31'd0, instr_valid}, 32'd1);
    chk("mr_addr", {10'd0, imem_addr}, 32'd2);
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 22'h55;
    step();
    reset = 1'b0;
    redirect_valid = 1'b0;
    chk("mr_v", {31'd0, instr_valid}, 32'd0);
    chk("mr_addr2", {10'd0, imem_addr}, 32'd0);
    decode_ready = 1'b1;
    exp_push(32'h100, 22'd0);
    exp_push(32'h101, 22'd1);
    repeat (3) step();
    reset = 1'b1;
    step();

    chk("sb_left", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
